flash_boot_loader: RTL

- Boot-time copier between the SPI flash pins and instruction memory.
- After reset release, it issues one SPI READ (0x03) to flash and streams NUM_WORDS 32-bit words.
- Each word is written into imem through a single-master Wishbone write port.
- It holds the rv32i core in reset until the copy completes. This replaces the simulation-only imem preload with real boot behaviour.

---
 rtl/flash_boot_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/flash_boot_loader.sv
// flash_boot_loader: copies NUM_WORDS 32-bit words from SPI flash into imem
// over a Wishbone write port, holding the core in reset until the copy ends.
module flash_boot_loader #(
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_0000,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        o_flash_sclk,
  output logic        o_flash_cs_n,
  output logic        o_flash_mosi,
  input  logic        i_flash_miso,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  output logic        o_boot_done,
  output logic        o_core_reset_n
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    WRITE,
    DONE
  } state_t;

  localparam logic [31:0] CMD_WORD   = {8'h03, FLASH_BASE};
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] LAST_INDEX = 16'(NUM_WORDS - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] div_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] word_idx;
  logic [30:0] cmd_sr;
  logic [31:0] rx_sr;

  logic spi_active;
  logic div_wrap;
  logic sclk_rise;
  logic sclk_fall;
  logic bit_last;
  logic wb_ack;
  logic word_last;

  // SCLK only toggles while a command or data word is being shifted.
  assign spi_active = (state == CMD) || (state == DATA);
  assign div_wrap   = (div_cnt == DIV_LAST);
  assign sclk_rise  = spi_active && div_wrap && !o_flash_sclk;
  assign sclk_fall  = spi_active && div_wrap && o_flash_sclk;
  // A bit completes on the falling edge, so phase changes leave SCLK low.
  assign bit_last   = sclk_fall && (bit_cnt == 5'd31);
  // An ack with strobe low is not a handshake.
  assign wb_ack     = i_wb_ack && o_wb_stb;
  assign word_last  = (word_idx == LAST_INDEX);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every register in
      // the design sees pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  // Next-state decode: command, then alternating data/write per word.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:  state_next = CMD;
      CMD:   if (bit_last) state_next = DATA;
      DATA:  if (bit_last) state_next = WRITE;
      WRITE: if (wb_ack) state_next = word_last ? DONE : DATA;
      DONE:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // SCLK divider: CLK_DIV clk per phase; bit counter advances on falling edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt      <= '0;
      o_flash_sclk <= 1'b0;
      bit_cnt      <= '0;
    end else if (!spi_active) begin
      div_cnt      <= '0;
      o_flash_sclk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt      <= '0;
      o_flash_sclk <= ~o_flash_sclk;
      if (o_flash_sclk) bit_cnt <= bit_cnt + 5'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Datapath: command shift-out, word shift-in, Wishbone write and boot status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_flash_cs_n   <= 1'b1;
      o_flash_mosi   <= 1'b0;
      cmd_sr         <= '0;
      rx_sr          <= '0;
      o_wb_cyc       <= 1'b0;
      o_wb_stb       <= 1'b0;
      o_wb_we        <= 1'b0;
      o_wb_adr       <= '0;
      o_wb_dat       <= '0;
      o_wb_sel       <= '0;
      word_idx       <= '0;
      o_boot_done    <= 1'b0;
      o_core_reset_n <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // First command bit is presented together with the CS_N fall.
          o_flash_cs_n <= 1'b0;
          o_flash_mosi <= CMD_WORD[31];
          cmd_sr       <= CMD_WORD[30:0];
        end
        CMD: begin
          if (sclk_fall) begin
            o_flash_mosi <= bit_last ? 1'b0 : cmd_sr[30];
            cmd_sr       <= {cmd_sr[29:0], 1'b0};
          end
        end
        DATA: begin
          if (sclk_rise) rx_sr <= {rx_sr[30:0], i_flash_miso};
          if (bit_last) begin
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_we  <= 1'b1;
            o_wb_sel <= 4'hF;
            o_wb_adr <= IMEM_BASE + {14'd0, word_idx, 2'b00};
            // First received byte is the least significant (little-endian).
            o_wb_dat <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
          end
        end
        WRITE: begin
          if (wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_sel <= 4'h0;
            word_idx <= word_idx + 16'd1;
            if (word_last) begin
              o_flash_cs_n <= 1'b1;
              o_boot_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          o_flash_cs_n   <= 1'b1;
          o_core_reset_n <= 1'b1;
        end
        default: o_flash_cs_n <= 1'b1;
      endcase
    end
  end

endmodule
